// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with 1-cycle-latency pixel fetch and 2-cycle aligned output pipeline.
// Optional internal x/y test pattern selected by test_mode when VGA_TESTPATTERN_EN is defined.
module vga_timing_gen #(
    parameter int unsigned WIDTH        = 640,
    parameter int unsigned HEIGHT       = 480,
    parameter int unsigned H_SYNC_CYC   = 96,
    parameter int unsigned H_SYNC_BACK  = 48,
    parameter int unsigned H_SYNC_FRONT = 16,
    parameter int unsigned V_SYNC_CYC   = 2,
    parameter int unsigned V_SYNC_BACK  = 33,
    parameter int unsigned V_SYNC_FRONT = 10
) (
    input  logic        VGA_CLK,
    input  logic        reset_n,
`ifdef VGA_TESTPATTERN_EN
    input  logic        test_mode,
`endif
    output logic        pix_req,
    output logic [12:0] pix_x,
    output logic [12:0] pix_y,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_BLANK_N,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_BLANK_I = H_SYNC_FRONT + H_SYNC_CYC + H_SYNC_BACK;
    localparam int unsigned V_BLANK_I = V_SYNC_FRONT + V_SYNC_CYC + V_SYNC_BACK;

    localparam logic [12:0] H_BLANK   = 13'(H_BLANK_I);
    localparam logic [12:0] H_LAST    = 13'(H_BLANK_I + WIDTH - 1);
    localparam logic [12:0] H_SYNC_LO = 13'(H_SYNC_FRONT);
    localparam logic [12:0] H_SYNC_HI = 13'(H_SYNC_FRONT + H_SYNC_CYC);
    localparam logic [12:0] V_BLANK   = 13'(V_BLANK_I);
    localparam logic [12:0] V_LAST    = 13'(V_BLANK_I + HEIGHT - 1);
    localparam logic [12:0] V_SYNC_LO = 13'(V_SYNC_FRONT);
    localparam logic [12:0] V_SYNC_HI = 13'(V_SYNC_FRONT + V_SYNC_CYC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic line;
        logic frame;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, default: 1'b0};

    logic [12:0] h_cnt;
    logic [12:0] v_cnt;
    ctrl_t       s0;
    ctrl_t       d1;
    ctrl_t       d2;
    logic        act0;
    logic [7:0]  rgb_r;
    logic [7:0]  rgb_g;
    logic [7:0]  rgb_b;
    logic [7:0]  src_r;
    logic [7:0]  src_g;
    logic [7:0]  src_b;

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 13'd1;
        end else begin
            h_cnt <= h_cnt + 13'd1;
        end
    end

    assign act0 = (h_cnt >= H_BLANK) && (v_cnt >= V_BLANK);

    always_comb begin
        s0        = CTRL_IDLE;
        s0.hs     = !((h_cnt > H_SYNC_LO) && (h_cnt <= H_SYNC_HI));
        s0.vs     = !((v_cnt > V_SYNC_LO) && (v_cnt <= V_SYNC_HI));
        s0.active = act0;
        s0.line   = act0 && (h_cnt == H_BLANK);
        s0.frame  = act0 && (h_cnt == H_BLANK) && (v_cnt == V_BLANK);
    end

    assign pix_req = act0;
    assign pix_x   = act0 ? h_cnt - H_BLANK : '0;
    assign pix_y   = act0 ? v_cnt - V_BLANK : '0;

`ifdef VGA_TESTPATTERN_EN
    // Pattern coordinates travel one stage alongside the request so they meet the source data.
    logic       d1_tm;
    logic [7:0] d1_x;
    logic [7:0] d1_y;

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            d1_tm <= 1'b0;
            d1_x  <= '0;
            d1_y  <= '0;
        end else begin
            d1_tm <= test_mode;
            d1_x  <= pix_x[7:0];
            d1_y  <= pix_y[7:0];
        end
    end

    always_comb begin
        src_r = pix_r;
        src_g = pix_g;
        src_b = pix_b;
        if (d1_tm) begin
            src_r = d1_x;
            src_g = d1_y;
            src_b = d1_x + d1_y;
        end
    end
`else
    assign src_r = pix_r;
    assign src_g = pix_g;
    assign src_b = pix_b;
`endif

    // Control takes two registers; colour only one, since the source already adds a cycle.
    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            d1          <= CTRL_IDLE;
            d2          <= CTRL_IDLE;
            rgb_r       <= '0;
            rgb_g       <= '0;
            rgb_b       <= '0;
            frame_count <= '0;
        end else begin
            d1 <= s0;
            d2 <= d1;
            if (d1.active) begin
                rgb_r <= src_r;
                rgb_g <= src_g;
                rgb_b <= src_b;
            end else begin
                rgb_r <= '0;
                rgb_g <= '0;
                rgb_b <= '0;
            end
            if (d1.frame) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    assign oVGA_HS      = d2.hs;
    assign oVGA_VS      = d2.vs;
    assign oVGA_BLANK_N = d2.active;
    assign oVGA_SYNC_N  = 1'b0;
    assign line_start   = d2.line;
    assign frame_start  = d2.frame;
    assign oVGA_R       = rgb_r;
    assign oVGA_G       = rgb_g;
    assign oVGA_B       = rgb_b;

endmodule
